// File: rtl/div_issue.sv
// div_issue: issue/capture stage around a combinational signed divider.
// Resolves divide-by-zero and MIN/-1 on accept; otherwise waits for the divider path to settle.
module div_issue #(
    parameter int WIDTH         = 32,
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_first_op,
    input  logic [WIDTH-1:0] i_second_op,
    output logic [WIDTH-1:0] o_div_a,
    output logic [WIDTH-1:0] o_div_b,
    input  logic [WIDTH-1:0] i_div_quot,
    input  logic [WIDTH-1:0] i_div_rem,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_quot,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_div_by_zero,
    output logic             o_overflow
);
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, quot_q, quot_d, rem_q, rem_d;
    logic             dz_q, dz_d, ov_q, ov_d;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
            ov_q    <= ov_d;
        end
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
        ov_d    = ov_q;
        case (state_q)
            S_IDLE: if (i_valid) begin
                a_d  = i_first_op;
                b_d  = i_second_op;
                dz_d = 1'b0;
                ov_d = 1'b0;
                if (i_second_op == '0) begin
                    quot_d  = '1;
                    rem_d   = i_first_op;
                    dz_d    = 1'b1;
                    state_d = S_HOLD;
                end else if (i_first_op == MIN && i_second_op == '1) begin
                    quot_d  = MIN;
                    rem_d   = '0;
                    ov_d    = 1'b1;
                    state_d = S_HOLD;
                end else begin
                    cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end else begin
                quot_d  = i_div_quot;
                rem_d   = i_div_rem;
                state_d = S_HOLD;
            end
            S_HOLD: state_d = i_ready ? S_IDLE : S_HOLD;
            default: state_d = S_IDLE;
        endcase
    end
    assign o_ready       = state_q == S_IDLE;
    assign o_valid       = state_q == S_HOLD;
    assign o_div_a       = a_q;
    assign o_div_b       = b_q;
    assign o_quot        = quot_q;
    assign o_rem         = rem_q;
    assign o_div_by_zero = dz_q;
    assign o_overflow    = ov_q;
endmodule

// File: tb/tb_div_issue.sv
// tb_div_issue: table, random and hand-written sequences for div_issue against an arithmetic model.
module tb_div_issue;
    localparam int W = 32;
    localparam int S = 2;
    localparam logic [W-1:0] MIN = 32'h8000_0000;
    typedef struct {
        logic [W-1:0] a, b, q, r;
        logic         dz, ov;
        int           lat;
    } vec_t;
    logic clk = 1'b0, rst = 1'b1, i_valid = 1'b0, i_ready = 1'b0;
    logic [W-1:0] a_in = '0, b_in = '0, dq = '0, dr = '0;
    logic o_ready, o_valid, o_dz, o_ov;
    logic [W-1:0] o_div_a, o_div_b, o_quot, o_rem;
    int checks = 0, failures = 0;
    div_issue #(.WIDTH(W), .SETTLE_CYCLES(S), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_first_op(a_in), .i_second_op(b_in), .o_div_a(o_div_a), .o_div_b(o_div_b),
        .i_div_quot(dq), .i_div_rem(dr), .o_valid(o_valid), .i_ready(i_ready),
        .o_quot(o_quot), .o_rem(o_rem), .o_div_by_zero(o_dz), .o_overflow(o_ov)
    );
    always #5 clk = ~clk;
    // Divider stand-in: results lag the operand registers by one clock, so only a settled capture is right.
    always @(posedge clk)
        if (o_div_b == '0 || (o_div_a == MIN && o_div_b == '1)) begin
            dq <= '0;
            dr <= '0;
        end else begin
            dq <= W'($signed(o_div_a) / $signed(o_div_b));
            dr <= W'($signed(o_div_a) % $signed(o_div_b));
        end
    task automatic check(input string n, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic dz, output logic ov, output int lat);
        longint sa, sb, ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        dz = 1'b0;
        ov = 1'b0;
        lat = 1;
        if (sb == 0) begin
            q = '1; r = a; dz = 1'b1;
        end else if (a == MIN && sb == -1) begin
            q = MIN; r = '0; ov = 1'b1;
        end else begin
            ua = sa < 0 ? -sa : sa;
            ub = sb < 0 ? -sb : sb;
            q = W'(((sa < 0) != (sb < 0)) ? -(ua / ub) : ua / ub);
            r = W'(sa < 0 ? -(ua % ub) : ua % ub);
            lat = S + 1;
        end
    endfunction
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!o_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask
    task automatic run(input string n, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eq, input logic [W-1:0] er,
                       input logic edz, input logic eov, input int elat);
        int lat;
        @(negedge clk);
        check({n, "_ready"}, W'(o_ready), 1);
        i_valid = 1'b1; a_in = a; b_in = b;
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0; a_in = $urandom; b_in = $urandom;
        wait_valid(lat);
        check({n, "_latency"}, W'(lat), W'(elat));
        check({n, "_quot"}, o_quot, eq);
        check({n, "_rem"}, o_rem, er);
        check({n, "_flags"}, W'({o_dz, o_ov}), W'({edz, eov}));
        check({n, "_div_ab"}, o_div_a ^ o_div_b, a ^ b);
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
        check({n, "_released"}, W'({o_valid, o_ready}), 32'd1);
    endtask
    vec_t tbl[9];
    initial begin
        logic [W-1:0] ra, rb, q, r;
        logic dz, ov;
        int lat;
        tbl[0] = '{32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 3};
        tbl[1] = '{-32'sd100, 32'd7, -32'sd14, -32'sd2, 1'b0, 1'b0, 3};
        tbl[2] = '{32'd7, -32'sd100, 32'd0, 32'd7, 1'b0, 1'b0, 3};
        tbl[3] = '{32'd55, 32'd0, 32'hFFFF_FFFF, 32'd55, 1'b1, 1'b0, 1};
        tbl[4] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1'b1, 1};
        tbl[5] = '{-32'sd7, 32'd2, -32'sd3, -32'sd1, 1'b0, 1'b0, 3};
        tbl[6] = '{32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0, 1'b0, 1'b0, 3};
        tbl[7] = '{32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 1'b0, 3};
        tbl[8] = '{32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1};
        repeat (2) @(negedge clk);
        check("reset_hs", W'({o_valid, o_ready}), 32'd1);
        check("reset_data", o_quot | o_rem | o_div_a | o_div_b, 0);
        check("reset_flags", W'({o_dz, o_ov}), 0);
        rst = 1'b0;
        foreach (tbl[i])
            run($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].dz, tbl[i].ov, tbl[i].lat);
        for (int i = 0; i < 40; i++) begin
            ra = ($urandom_range(0, 7) == 0) ? MIN : $urandom;
            rb = ($urandom_range(0, 5) == 0) ? 32'd0 : ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF :
                 ($urandom_range(0, 1) == 0) ? W'($signed($urandom_range(0, 200)) - 100) : $urandom;
            model(ra, rb, q, r, dz, ov, lat);
            run($sformatf("rnd%0d", i), ra, rb, q, r, dz, ov, lat);
        end
        // Consumer stalls in HOLD while a second request waits on i_valid.
        @(negedge clk);
        i_valid = 1'b1; a_in = 32'd100; b_in = 32'd7;
        @(posedge clk);
        @(negedge clk);
        a_in = 32'd200; b_in = 32'd3;
        wait_valid(lat);
        check("stall_latency", W'(lat), 32'd3);
        for (int i = 0; i < 5; i++) begin
            check("stall_hs", W'({o_valid, o_ready}), 32'd2);
            check("stall_data", o_quot ^ {o_rem[15:0], 16'h0}, 32'd14 ^ {16'd2, 16'h0});
            check("stall_div_a", o_div_a, 32'd100);
            @(negedge clk);
        end
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
        check("stall_release", W'({o_valid, o_ready, o_div_a[7:0]}), {22'd0, 2'b01, 8'd100});
        @(negedge clk);
        i_valid = 1'b0;
        check("stall_second_accept", W'({o_ready, o_div_a[7:0], o_div_b[7:0]}), {15'd0, 1'b0, 8'd200, 8'd3});
        wait_valid(lat);
        check("stall_second_quot", o_quot, 32'd66);
        check("stall_second_rem", o_rem, 32'd2);
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
        // Reset lands mid-WAIT; the in-flight request must vanish.
        i_valid = 1'b1; a_in = 32'd100; b_in = 32'd7;
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_wait_hs", W'({o_valid, o_ready}), 32'd1);
        check("rst_wait_data", o_quot | o_rem | o_div_a | o_div_b, 0);
        check("rst_wait_flags", W'({o_dz, o_ov}), 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_no_stale", W'({o_valid, o_ready}), 32'd1);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
